vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_ACTIVE, 800, visible pixels per line.
- H_FRONT, 40, front porch pixels.
- H_SYNC, 128, hsync width.
- H_BACK, 88, back porch pixels.
- V_ACTIVE, 600, visible lines.
- V_FRONT, 1, front porch lines.
- V_SYNC, 4, vsync lines.
- V_BACK, 23, back porch lines.
- HS_POL, 1, hsync asserted level.
- VS_POL, 1, vsync asserted level.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clock_in  in  1  40 MHz pixel clock from the PLL, the sole clock.
- reset_n  in  1  asynchronous active-low reset.
- locked  in  1  PLL lock, asynchronous to clock_in.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- active  out  1  pixel in visible area.
- x  out  11  pixel column, 0..H_ACTIVE-1 when active.
- y  out  10  pixel row, 0..V_ACTIVE-1 when active.
- line_start  out  1  one-cycle pulse at h=0.
- frame_start  out  1  one-cycle pulse at h=0,v=0.
- running  out  1  synchronised lock, timing advancing.

Function
REQ-003 H_TOTAL SHALL be the sum of the four H parameters (1056), and V_TOTAL SHALL be the sum of the four V parameters (628).
REQ-004 locked SHALL pass through a 2-flop synchroniser; the second stage SHALL drive running.
REQ-005 While running=0, h_cnt and v_cnt SHALL be held at 0.
REQ-006 While running=1, h_cnt SHALL increment each cycle and wrap from H_TOTAL-1 to 0.
REQ-007 v_cnt SHALL increment only when h_cnt wraps, and SHALL wrap from V_TOTAL-1 to 0 when h_cnt and v_cnt wrap together.
REQ-008 Outputs SHALL be registered from the counter state with exactly one cycle of latency, so all outputs are mutually aligned.
REQ-009 active SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-010 hsync SHALL equal HS_POL iff H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC (840..967); otherwise it SHALL be !HS_POL.
REQ-011 vsync SHALL equal VS_POL iff V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC (601..604); vsync SHALL change only together with h_cnt=0.
REQ-012 x SHALL equal h_cnt and y SHALL equal v_cnt when active=1; both SHALL be 0 when active=0.
REQ-013 line_start SHALL pulse for the h_cnt=0 cycle, and frame_start SHALL pulse for the (0,0) cycle, only while running=1.
REQ-014 Loss of lock (running 1->0) mid-frame SHALL reset the counters to (0,0) on the next edge.
REQ-015 When lock returns, the first advancing cycle SHALL present (0,0) and the first frame_start SHALL follow 1 cycle later.
REQ-016 While running=0, outputs SHALL be idle: hsync=!HS_POL, vsync=!VS_POL, active=0, x=0, y=0, pulses=0.
REQ-017 Any parameter change SHALL resize the timing with no other logic change; counter widths SHALL be fixed at 11/10 bits.

Reset
REQ-018 reset_n=0 SHALL asynchronously clear the synchroniser, the counters and all output registers to the idle values of REQ-016.
REQ-019 Deassertion of reset_n SHALL take effect on clock_in edges only, and running SHALL be 0 for at least 2 cycles after deassertion.
REQ-020 Reset asserted mid-frame SHALL drop outputs to idle immediately, without waiting for a clock edge.

Verification
REQ-021 Startup: reset_n released with locked=1 -> running rises at cycle 2, frame_start at cycle 3 with x=0,y=0,active=1.
REQ-022 Line timing: free run -> active high for 800 consecutive cycles, hsync high for 128 cycles starting 840 cycles after line_start, line_start period 1056.
REQ-023 Frame timing: free run -> frame_start period 663168 cycles, vsync high for 4224 cycles starting at line 601, 600 lines with any active=1.
REQ-024 Lock glitch: drop locked at h=500,v=300 for 10 cycles -> outputs idle within 3 cycles, and on relock frame_start occurs with x=0,y=0.
REQ-025 Async reset: assert reset_n=0 between clock edges at h=845 -> hsync=0 and active=0 before the next edge.
REQ-026 Polarity: HS_POL=0, VS_POL=0 -> hsync and vsync idle high and pulse low with the same windows as REQ-022 and REQ-023.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// Generates VGA horizontal/vertical timing from a single pixel clock.
// The PLL lock flag is synchronised into the pixel domain. The timing
// counters advance only while the synchronised lock is high. All video
// outputs are registered from the counter state, so they are mutually
// aligned and lag the counters by one cycle.
//
// Ports:
//   clock_in     in   pixel clock (sole clock)
//   reset_n      in   asynchronous active-low reset
//   locked       in   PLL lock, asynchronous to clock_in
//   hsync        out  horizontal sync (asserted level HS_POL)
//   vsync        out  vertical sync   (asserted level VS_POL)
//   active       out  pixel lies in the visible area
//   x            out  pixel column while active, else 0
//   y            out  pixel row while active, else 0
//   line_start   out  one-cycle pulse for the h=0 pixel
//   frame_start  out  one-cycle pulse for the (0,0) pixel
//   running      out  synchronised lock; timing is advancing
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FRONT  = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BACK   = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FRONT  = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BACK   = 23,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        locked,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic        running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Boundaries pre-sized to the fixed counter widths.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    logic lock_meta_q;
    logic lock_sync_q;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign running = lock_sync_q;

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;

    // Counters collapse to (0,0) on any cycle without lock, so a relock
    // always begins a fresh frame.
    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (lock_sync_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered)
    // ------------------------------------------------------------------
    logic        h_vis, v_vis, h_in_sync, v_in_sync;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        active_q, active_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    assign h_vis     = (h_cnt_q < H_VIS_END);
    assign v_vis     = (v_cnt_q < V_VIS_END);
    assign h_in_sync = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    assign v_in_sync = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);

    // Decoding is gated by the synchronised lock rather than by the
    // counter values, so the cycle in which lock is lost still shows the
    // last valid pixel and everything goes idle one cycle later.
    always_comb begin
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        active_d      = 1'b0;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (lock_sync_q) begin
            hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
            vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
            active_d      = h_vis && v_vis;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (h_vis && v_vis) begin
                x_d = h_cnt_q;
                y_d = v_cnt_q;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
